// File: rtl/gray_codec_pipe.sv
// Pipelined Gray<->binary converter with valid/ready handshake and per-stage backpressure.
// Optional sticky Gray-sequence checker is built when GRAY_CHECK_EN is defined.
module gray_codec_pipe #(
    parameter int PTR    = 4,
    parameter int STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_mode,
    input  logic [PTR-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_mode,
    output logic [PTR-1:0] out_data,
    output logic           gray_err
);

    // Number of Gray->binary bits resolved per stage, MSB slice first.
    localparam int SLICE = (PTR + STAGES - 1) / STAGES;

    // Resolve bits hi..lo of a partially converted word whose bits above hi are
    // already binary; bits outside the window pass through untouched.
    function automatic logic [PTR-1:0] resolve_slice(
        input logic [PTR-1:0] word,
        input int             hi,
        input int             lo
    );
        logic [PTR-1:0] res;
        res = word;
        for (int i = PTR - 2; i >= 0; i--) begin
            if (i <= hi && i >= lo) begin
                res[i] = res[i+1] ^ res[i];
            end
        end
        return res;
    endfunction

    logic [STAGES-1:0]     valid_reg;
    logic [STAGES-1:0]     mode_reg;
    logic [PTR-1:0]        data_reg [STAGES];
    logic [STAGES-1:0]     load;
    logic [STAGES-1:0]     src_valid;
    logic [STAGES-1:0]     src_mode;
    logic [STAGES*PTR-1:0] data_next;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            localparam int HI = PTR - 1 - gi * SLICE;
            localparam int LO = (HI - SLICE + 1 > 0) ? (HI - SLICE + 1) : 0;

            if (gi == 0) begin : g_first
                assign src_valid[gi] = in_valid;
                assign src_mode[gi]  = in_mode;
                assign data_next[gi*PTR +: PTR] = in_mode
                    ? (in_data ^ (in_data >> 1))
                    : resolve_slice(in_data, HI, LO);
            end else begin : g_later
                // Binary->Gray finished in stage 1, so later stages only delay it.
                assign src_valid[gi] = valid_reg[gi-1];
                assign src_mode[gi]  = mode_reg[gi-1];
                assign data_next[gi*PTR +: PTR] = mode_reg[gi-1]
                    ? data_reg[gi-1]
                    : resolve_slice(data_reg[gi-1], HI, LO);
            end
        end
    endgenerate

    // A stage may load when any stage from it to the output is empty or the sink drains.
    always_comb begin
        load = '0;
        for (int s = 0; s < STAGES; s++) begin
            load[s] = out_ready;
            for (int t = s; t < STAGES; t++) begin
                if (!valid_reg[t]) begin
                    load[s] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
            mode_reg  <= '0;
            for (int s = 0; s < STAGES; s++) begin
                data_reg[s] <= '0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (load[s]) begin
                    valid_reg[s] <= src_valid[s];
                    if (src_valid[s]) begin
                        mode_reg[s] <= src_mode[s];
                        data_reg[s] <= data_next[s*PTR +: PTR];
                    end
                end
            end
        end
    end

    assign in_ready  = load[0];
    assign out_valid = valid_reg[STAGES-1];
    assign out_mode  = mode_reg[STAGES-1];
    assign out_data  = data_reg[STAGES-1];

`ifdef GRAY_CHECK_EN
    localparam logic [PTR-1:0] ONE = PTR'(1);

    logic [PTR-1:0] prev_reg;
    logic           prev_seen_reg;
    logic           err_reg;
    logic [PTR-1:0] diff;

    // diff & (diff-1) is nonzero exactly when more than one bit differs.
    assign diff = in_data ^ prev_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_reg      <= '0;
            prev_seen_reg <= 1'b0;
            err_reg       <= 1'b0;
        end else if (in_valid && load[0] && !in_mode) begin
            if (prev_seen_reg && ((diff & (diff - ONE)) != '0)) begin
                err_reg <= 1'b1;
            end
            prev_reg      <= in_data;
            prev_seen_reg <= 1'b1;
        end
    end

    assign gray_err = err_reg;
`else
    assign gray_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Bench for gray_codec_pipe: vector table, directed stall/reset/error sequences,
// random traffic against a queue model, and an 8-bit exhaustive round trip.
module tb_gray_codec_pipe;

    localparam int PTR    = 4;
    localparam int STAGES = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, in_mode;
    logic [3:0] in_data;
    logic       out_valid, out_ready, out_mode;
    logic [3:0] out_data;
    logic       gray_err;

    logic       in8_valid, in8_ready, in8_mode;
    logic [7:0] in8_data;
    logic       out8_valid, out8_ready, out8_mode;
    logic [7:0] out8_data;
    logic       gray8_err;

    always #5 clk = ~clk;

    gray_codec_pipe #(.PTR(PTR), .STAGES(STAGES)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode), .out_data(out_data),
        .gray_err(gray_err)
    );

    gray_codec_pipe #(.PTR(8), .STAGES(3)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in8_valid), .in_ready(in8_ready), .in_mode(in8_mode), .in_data(in8_data),
        .out_valid(out8_valid), .out_ready(out8_ready), .out_mode(out8_mode), .out_data(out8_data),
        .gray_err(gray8_err)
    );

    typedef struct {
        logic       mode;
        logic [3:0] data;
        int         cyc;
    } beat_t;

    typedef struct {
        logic       mode;
        logic [3:0] din;
        logic [3:0] dout;
    } vec_t;

    beat_t      q[$];
    logic [3:0] got[$];
    int         got_cyc[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic       check_lat = 1'b0;
    logic       exp_err = 1'b0;
    logic       prev_seen = 1'b0;
    logic [3:0] prev_g = 4'b0;

    // Gray->binary as the prefix XOR of all right shifts of the code.
    function automatic logic [7:0] g2b(input logic [7:0] g);
        logic [7:0] b;
        b = 8'h00;
        for (int k = 0; k < 8; k++) b = b ^ (g >> k);
        return b;
    endfunction

    function automatic logic [7:0] b2g(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [3:0] conv4(input logic m, input logic [3:0] d);
        logic [7:0] w;
        w = m ? b2g({4'b0, d}) : g2b({4'b0, d});
        return w[3:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle on the 4-bit DUT: drive, check against the model, advance.
    task automatic step(input logic v, input logic m, input logic [3:0] d, input logic ordy);
        beat_t b;
        in_valid  = v;
        in_mode   = m;
        in_data   = d;
        out_ready = ordy;
        #1;
        chk("in_ready", in_ready, ordy || (q.size() < STAGES));
        chk("gray_err", gray_err, exp_err);
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("phantom_beat", out_valid, 1'b0);
            end else begin
                chk("out_data", out_data, q[0].data);
                chk("out_mode", out_mode, q[0].mode);
                if (ordy) begin
                    if (check_lat) chk("latency", cyc - q[0].cyc, STAGES);
                    $display("beat cyc=%0d mode=%0d out=%b latency=%0d",
                             cyc, out_mode, out_data, cyc - q[0].cyc);
                    got.push_back(out_data);
                    got_cyc.push_back(cyc);
                    void'(q.pop_front());
                end
            end
        end
        if (v && in_ready) begin
            b.mode = m;
            b.data = conv4(m, d);
            b.cyc  = cyc;
            q.push_back(b);
`ifdef GRAY_CHECK_EN
            if (!m) begin
                if (prev_seen && ($countones(d ^ prev_g) > 1)) exp_err = 1'b1;
                prev_g    = d;
                prev_seen = 1'b1;
            end
`endif
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
        q.delete();
        exp_err   = 1'b0;
        prev_seen = 1'b0;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_data", out_data, 4'b0);
        chk("rst_out_mode", out_mode, 1'b0);
        chk("rst_gray_err", gray_err, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() > 0; i++) step(1'b0, 1'b0, 4'b0, 1'b1);
        chk("drain_empty", q.size(), 0);
    endtask

    vec_t vecs[9];
    logic [7:0] res[256];

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int k;
        logic [3:0] exp_seq[3];

        rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_data = 4'b0; out_ready = 1'b0;
        in8_valid = 1'b0; in8_mode = 1'b0; in8_data = 8'b0; out8_ready = 1'b0;

        vecs[0] = '{1'b0, 4'b1101, 4'b1001};
        vecs[1] = '{1'b0, 4'b1000, 4'b1111};
        vecs[2] = '{1'b1, 4'b0111, 4'b0100};
        vecs[3] = '{1'b1, 4'b1001, 4'b1101};
        vecs[4] = '{1'b0, 4'b1111, 4'b1010};
        vecs[5] = '{1'b0, 4'b0000, 4'b0000};
        vecs[6] = '{1'b1, 4'b1111, 4'b1000};
        vecs[7] = '{1'b1, 4'b0000, 4'b0000};
        vecs[8] = '{1'b0, 4'b0110, 4'b0100};

        @(posedge clk);
        #1;
        do_reset();

        // Single beats from the table, each timed from transfer to out_valid.
        check_lat = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step(1'b1, vecs[i].mode, vecs[i].din, 1'b1);
            lat = 1;
            while (!out_valid && lat < 8) begin
                step(1'b0, 1'b0, 4'b0, 1'b1);
                lat++;
            end
            chk("vec_latency", lat, STAGES);
            chk("vec_data", out_data, vecs[i].dout);
            chk("vec_mode", out_mode, vecs[i].mode);
            drain();
        end

        // Back-to-back mixed modes stream at one beat per cycle.
        got.delete(); got_cyc.delete();
        exp_seq[0] = 4'b1111; exp_seq[1] = 4'b0100; exp_seq[2] = 4'b1101;
        step(1'b1, 1'b0, 4'b1000, 1'b1);
        step(1'b1, 1'b1, 4'b0111, 1'b1);
        step(1'b1, 1'b1, 4'b1001, 1'b1);
        drain();
        chk("b2b_count", got.size(), 3);
        for (int i = 0; i < 3 && i < got.size(); i++) chk("b2b_data", got[i], exp_seq[i]);
        if (got.size() == 3) chk("b2b_span", got_cyc[2] - got_cyc[0], 2);

        // Stall: fill both stages, hold the sink off for 5 cycles, then release.
        check_lat = 1'b0;
        got.delete(); got_cyc.delete();
        step(1'b1, 1'b0, 4'b0011, 1'b0);
        step(1'b1, 1'b1, 4'b0101, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 4'b1110, 1'b0);
        out_ready = 1'b0;
        #1;
        chk("stall_in_ready", in_ready, 1'b0);
        chk("stall_out_data", out_data, 4'b0010);
        step(1'b1, 1'b1, 4'b1110, 1'b1);
        drain();
        chk("stall_count", got.size(), 3);
        if (got.size() == 3) begin
            chk("stall_beat0", got[0], 4'b0010);
            chk("stall_beat1", got[1], 4'b0111);
            chk("stall_beat2", got[2], 4'b1001);
        end

        // Reset with two beats in flight: nothing from them may emerge.
        step(1'b1, 1'b0, 4'b1100, 1'b0);
        step(1'b1, 1'b1, 4'b0110, 1'b0);
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 4'b0, 1'b1);

        // Gray-sequence checker: the fourth code is two bits away from the third.
        step(1'b1, 1'b0, 4'b0000, 1'b1);
        step(1'b1, 1'b0, 4'b0001, 1'b1);
        step(1'b1, 1'b0, 4'b0011, 1'b1);
        chk("gray_err_before", gray_err, 1'b0);
        step(1'b1, 1'b0, 4'b0101, 1'b1);
`ifdef GRAY_CHECK_EN
        chk("gray_err_set", gray_err, 1'b1);
`else
        chk("gray_err_set", gray_err, 1'b0);
`endif
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 4'($urandom_range(0, 15)), 1'b1);
        drain();
        do_reset();

        // Random traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
        end
        drain();

        // 8-bit exhaustive: binary->Gray for every value, then back again.
        k = 0;
        for (int c = 0; c < 266; c++) begin
            in8_valid = (c < 256); in8_mode = 1'b1; in8_data = c[7:0]; out8_ready = 1'b1;
            #1;
            chk("in8_ready", in8_ready, 1'b1);
            if (out8_valid) begin
                if (k < 256) begin
                    chk("exh_b2g", out8_data, b2g(k[7:0]));
                    chk("exh_mode1", out8_mode, 1'b1);
                    res[k] = out8_data;
                end
                $display("exh b2g idx=%0d out=%b", k, out8_data);
                k++;
            end
            @(posedge clk);
            #1;
        end
        chk("exh_count_b2g", k, 256);
        k = 0;
        for (int c = 0; c < 266; c++) begin
            in8_valid = (c < 256); in8_mode = 1'b0; in8_data = (c < 256) ? res[c] : 8'h00;
            out8_ready = 1'b1;
            #1;
            if (out8_valid) begin
                if (k < 256) begin
                    chk("exh_g2b", out8_data, k[7:0]);
                    chk("exh_mode0", out8_mode, 1'b0);
                end
                $display("exh g2b idx=%0d out=%b", k, out8_data);
                k++;
            end
            @(posedge clk);
            #1;
        end
        in8_valid = 1'b0;
        chk("exh_count_g2b", k, 256);
        chk("exh_gray_err", gray8_err, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
